tensor_core_scheduler: RTL and testbench
========================================

// Module: tensor_core_scheduler
// PURPOSE
//  Shares the single small tensor core between NUM_REQ requesters (CPU decode, host port).
//  Round-robin arbitration, then sequences one matmul job: start, wait for done,
//  bulk write-back into the tensor-core register file, respond.
//  Sits between instruction decode and small_tensor_core / tensor_core_register_file.
//  Blocks non-bulk register-file writes while the core computes.
// PARAMETERS
//  NUM_REQ         2   number of requesters (>=1)
//  TIMEOUT_CYCLES  64  max WAIT cycles before a job is aborted with error (>=2)
//  CNT_W (local)       $clog2(TIMEOUT_CYCLES+1), width of the WAIT counter
// PORTS
//  clock_in              in   1        single clock, rising edge
//  reset_n_in            in   1        asynchronous, active-low reset
//  req_valid_in          in   NUM_REQ  per-requester job request, level
//  req_ready_out         out  NUM_REQ  one-hot accept pulse; job taken when valid&ready
//  rsp_valid_out         out  NUM_REQ  one-hot 1-cycle completion pulse to job owner
//  rsp_error_out         out  1        qualifies rsp_valid_out: 1 = timeout abort
//  busy_out              out  1        high in every state except IDLE
//  tc_start_out          out  1        1-cycle start pulse to tensor core
//  tc_done_in            in   1        tensor core is_done_with_calculation
//  rf_bulk_write_en_out  out  1        1-cycle bulk write of result into register file
//  rf_write_block_out    out  1        suppress non-bulk RF writes (START/WAIT/WRITEBACK)
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=NUM_REQ-1 (req 0 wins first), counter=0, owner=0, all outputs 0.
//  Reset asserted mid-job: job dropped, no response issued, core not restarted.
//  FSM: IDLE -> START -> WAIT -> {WRITEBACK -> RESPOND | RESPOND} -> IDLE.
//  IDLE: if any valid, winner = first valid at or after ptr+1 (mod NUM_REQ);
//   req_ready_out[winner]=1 combinationally this cycle; latch owner, ptr<=winner; ->START.
//   req_ready_out is 0 in all other states; valid may rise/fall freely before accept.
//  START: tc_start_out=1, counter<=0; tc_done_in ignored (stale); ->WAIT.
//  WAIT: counter++ each cycle; tc_done_in=1 ->WRITEBACK (done wins over timeout if same cycle);
//   else counter==TIMEOUT_CYCLES-1 -> RESPOND with error flag set.
//  WRITEBACK: rf_bulk_write_en_out=1 one cycle; ->RESPOND.
//  RESPOND: rsp_valid_out[owner]=1, rsp_error_out=error flag; clear flag; ->IDLE.
//  Latency accept->rsp: min 4 cycles (done in first WAIT cycle); timeout rsp at accept+TIMEOUT_CYCLES+2.
//  No back-to-back: next accept earliest cycle after RESPOND (IDLE for >=1 cycle).
//  All outputs registered except req_ready_out (decoded from state + arbiter).
//  Counter saturates logic-wise; never wraps (exits WAIT at TIMEOUT_CYCLES-1).
// CONFIGURATION
//  TENSOR_SCHED_PERF_EN defined: adds outputs perf_jobs_out[15:0] (++ per RESPOND without error,
//   wraps at 16'hFFFF->0), perf_timeouts_out[7:0] (++ per error RESPOND, saturates at 8'hFF),
//   perf_busy_cycles_out[31:0] (++ every cycle busy_out=1, wraps); all 0 on reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  tensor_core_pkg: sched_state_t enum (IDLE,START,WAIT,WRITEBACK,RESPOND), default
//   TIMEOUT_CYCLES constant, shared tensor core opcode constants.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer in, one-hot grant + index out, combinational.
//  FSM, counter, owner/error registers and perf counters stay in tensor_core_scheduler.
// TESTING
//  1 Reset: reset_n_in=0 async mid-WAIT -> all outputs 0 same cycle, state IDLE, no rsp after release.
//  2 Single job: NUM_REQ=2, req_valid=2'b01, done 3 cycles after start -> ready=01 at t0,
//    tc_start t1, bulk_wr t5, rsp_valid=01 error=0 at t6.
//  3 Fairness: req_valid=2'b11 held, done immediate -> grants alternate 01,10,01,10; req 0 first.
//  4 Timeout: TIMEOUT_CYCLES=8, tc_done_in never -> no bulk write, rsp_error_out=1 at accept+10.
//  5 Stale/race: done high during START ignored; done on last WAIT cycle -> write-back, error=0.
//  6 PERF_EN: 3 ok jobs + 1 timeout -> perf_jobs=3, perf_timeouts=1, busy_cycles = sum of busy.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core scheduler and its neighbours.
package tensor_core_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT      = 3'd2,
    WRITEBACK = 3'd3,
    RESPOND   = 3'd4
  } sched_state_t;

  localparam int unsigned TC_DEFAULT_NUM_REQ        = 2;
  localparam int unsigned TC_DEFAULT_TIMEOUT_CYCLES = 64;

  // Opcodes understood by small_tensor_core, shared with instruction decode.
  localparam logic [3:0] TC_OP_NOP    = 4'h0;
  localparam logic [3:0] TC_OP_MATMUL = 4'h1;
  localparam logic [3:0] TC_OP_LOAD   = 4'h2;
  localparam logic [3:0] TC_OP_STORE  = 4'h3;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after i_ptr+1 wins.
module rr_arbiter
  import tensor_core_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  assign o_any = |i_req;

  always_comb begin : arb
    logic [IDX_W-1:0] cand;
    logic             found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(i_ptr) + i) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

endmodule

// File: rtl/tensor_core_scheduler.sv
// Arbitrates requesters onto the single tensor core and sequences one job at a time.
// Optional TENSOR_SCHED_PERF_EN adds job/timeout/busy performance counters.
module tensor_core_scheduler
  import tensor_core_pkg::*;
#(
  parameter int unsigned NUM_REQ        = TC_DEFAULT_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = TC_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clock_in,
  input  logic               reset_n_in,
  input  logic [NUM_REQ-1:0] req_valid_in,
  output logic [NUM_REQ-1:0] req_ready_out,
  output logic [NUM_REQ-1:0] rsp_valid_out,
  output logic               rsp_error_out,
  output logic               busy_out,
  output logic               tc_start_out,
  input  logic               tc_done_in,
  output logic               rf_bulk_write_en_out,
  output logic               rf_write_block_out
`ifdef TENSOR_SCHED_PERF_EN
  ,
  output logic [15:0]        perf_jobs_out,
  output logic [7:0]         perf_timeouts_out,
  output logic [31:0]        perf_busy_cycles_out
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t       r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_error;
  logic               r_busy;
  logic               r_tc_start;
  logic               r_bulk_wr;
  logic               r_wr_block;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic [NUM_REQ-1:0] w_owner_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (req_valid_in),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_owner_oh = NUM_REQ'(1) << r_owner;

  // Accept is the only combinational output; it is held low while reset is asserted.
  assign req_ready_out = (reset_n_in && (r_state == IDLE)) ? w_grant : '0;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= IDLE;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_owner     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_error <= 1'b0;
      r_busy      <= 1'b0;
      r_tc_start  <= 1'b0;
      r_bulk_wr   <= 1'b0;
      r_wr_block  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= START;
            r_owner    <= w_grant_idx;
            r_ptr      <= w_grant_idx;
            r_busy     <= 1'b1;
            r_tc_start <= 1'b1;
            r_wr_block <= 1'b1;
          end
        end
        START: begin
          // Any done seen here belongs to a previous job and is ignored.
          r_state    <= WAIT;
          r_tc_start <= 1'b0;
          r_cnt      <= '0;
        end
        WAIT: begin
          if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (tc_done_in) begin
            r_state   <= WRITEBACK;
            r_bulk_wr <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= RESPOND;
            r_err       <= 1'b1;
            r_wr_block  <= 1'b0;
            r_rsp_valid <= w_owner_oh;
            r_rsp_error <= 1'b1;
          end
        end
        WRITEBACK: begin
          r_state     <= RESPOND;
          r_bulk_wr   <= 1'b0;
          r_wr_block  <= 1'b0;
          r_rsp_valid <= w_owner_oh;
          r_rsp_error <= r_err;
        end
        RESPOND: begin
          r_state     <= IDLE;
          r_err       <= 1'b0;
          r_rsp_valid <= '0;
          r_rsp_error <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_err       <= 1'b0;
          r_rsp_valid <= '0;
          r_rsp_error <= 1'b0;
          r_busy      <= 1'b0;
          r_tc_start  <= 1'b0;
          r_bulk_wr   <= 1'b0;
          r_wr_block  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_out        = r_rsp_valid;
  assign rsp_error_out        = r_rsp_error;
  assign busy_out             = r_busy;
  assign tc_start_out         = r_tc_start;
  assign rf_bulk_write_en_out = r_bulk_wr;
  assign rf_write_block_out   = r_wr_block;

`ifdef TENSOR_SCHED_PERF_EN
  logic [15:0] r_perf_jobs;
  logic [7:0]  r_perf_timeouts;
  logic [31:0] r_perf_busy;

  // Jobs wrap, timeouts saturate, busy cycles wrap.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_perf_jobs     <= '0;
      r_perf_timeouts <= '0;
      r_perf_busy     <= '0;
    end else begin
      if ((r_state == RESPOND) && !r_err) begin
        r_perf_jobs <= r_perf_jobs + 16'd1;
      end
      if ((r_state == RESPOND) && r_err && (r_perf_timeouts != 8'hFF)) begin
        r_perf_timeouts <= r_perf_timeouts + 8'd1;
      end
      if (r_busy) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
    end
  end

  assign perf_jobs_out        = r_perf_jobs;
  assign perf_timeouts_out    = r_perf_timeouts;
  assign perf_busy_cycles_out = r_perf_busy;
`endif

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Directed + randomized bench for tensor_core_scheduler with a job-level reference model.
module tb_tensor_core_scheduler;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TO   = 8;

  logic            clock_in = 1'b0;
  logic            reset_n_in = 1'b0;
  logic [NREQ-1:0] req_valid_in = '0;
  logic [NREQ-1:0] req_ready_out;
  logic [NREQ-1:0] rsp_valid_out;
  logic            rsp_error_out;
  logic            busy_out;
  logic            tc_start_out;
  logic            tc_done_in = 1'b0;
  logic            rf_bulk_write_en_out;
  logic            rf_write_block_out;
`ifdef TENSOR_SCHED_PERF_EN
  logic [15:0]     perf_jobs_out;
  logic [7:0]      perf_timeouts_out;
  logic [31:0]     perf_busy_cycles_out;
`endif

  tensor_core_scheduler #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock_in             (clock_in),
    .reset_n_in           (reset_n_in),
    .req_valid_in         (req_valid_in),
    .req_ready_out        (req_ready_out),
    .rsp_valid_out        (rsp_valid_out),
    .rsp_error_out        (rsp_error_out),
    .busy_out             (busy_out),
    .tc_start_out         (tc_start_out),
    .tc_done_in           (tc_done_in),
    .rf_bulk_write_en_out (rf_bulk_write_en_out),
    .rf_write_block_out   (rf_write_block_out)
`ifdef TENSOR_SCHED_PERF_EN
    ,
    .perf_jobs_out        (perf_jobs_out),
    .perf_timeouts_out    (perf_timeouts_out),
    .perf_busy_cycles_out (perf_busy_cycles_out)
`endif
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  // Model state: index of the last accepted requester, and perf tallies since reset.
  int last_w  = NREQ - 1;
  int m_jobs  = 0;
  int m_tos   = 0;
  int m_busy  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner: both requesting -> the one not served last; otherwise the lone requester.
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    if (v[0]) return 0;
    return 1;
  endfunction

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // One job. done_k = WAIT cycle (1..TO) carrying done, 0 = never (timeout).
  task automatic run_job(input logic [1:0] v, input int done_k, input bit stale, input bit hold);
    int w;
    int t_acc;
    int lat;
    step();
    req_valid_in = v;
    tc_done_in   = 1'b0;
    #1;
    w = pick(v, last_w);
    check("accept_ready", 32'(req_ready_out), 32'(1) << w);
    check("idle_not_busy", 32'(busy_out), 32'd0);
    last_w = w;
    t_acc  = cyc;
    step();
    req_valid_in = hold ? v : 2'b00;
    tc_done_in   = stale;
    #1;
    check("start_pulse", 32'(tc_start_out), 32'd1);
    check("start_busy", 32'(busy_out), 32'd1);
    check("start_block", 32'(rf_write_block_out), 32'd1);
    check("start_no_ready", 32'(req_ready_out), 32'd0);
    for (int k = 1; k <= int'(TO); k++) begin
      step();
      tc_done_in = (k == done_k);
      #1;
      check("wait_start_low", 32'(tc_start_out), 32'd0);
      check("wait_no_bulk", 32'(rf_bulk_write_en_out), 32'd0);
      check("wait_no_ready", 32'(req_ready_out), 32'd0);
      if (k == done_k) break;
    end
    if (done_k > 0) begin
      step();
      tc_done_in = 1'b0;
      #1;
      check("bulk_write", 32'(rf_bulk_write_en_out), 32'd1);
      check("wb_block", 32'(rf_write_block_out), 32'd1);
      check("wb_no_rsp", 32'(rsp_valid_out), 32'd0);
      lat = 3 + done_k;
    end else begin
      lat = int'(TO) + 2;
    end
    step();
    tc_done_in = 1'b0;
    #1;
    check("rsp_valid", 32'(rsp_valid_out), 32'(1) << w);
    check("rsp_error", 32'(rsp_error_out), (done_k == 0) ? 32'd1 : 32'd0);
    check("rsp_latency", 32'(cyc - t_acc), 32'(lat));
    check("rsp_no_bulk", 32'(rf_bulk_write_en_out), 32'd0);
    check("rsp_unblock", 32'(rf_write_block_out), 32'd0);
    step();
    req_valid_in = 2'b00;
    #1;
    check("back_idle", 32'(busy_out), 32'd0);
    check("rsp_pulse_end", 32'(rsp_valid_out), 32'd0);
    if (done_k == 0) begin
      if (m_tos < 255) m_tos++;
    end else begin
      m_jobs++;
    end
    m_busy += lat;
  endtask

  initial begin
    // Reset with requests pending: every output must stay 0.
    req_valid_in = 2'b11;
    #1;
    check("rst_ready", 32'(req_ready_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_rsp", 32'(rsp_valid_out), 32'd0);
    check("rst_start", 32'(tc_start_out), 32'd0);
    check("rst_block", 32'(rf_write_block_out), 32'd0);
    repeat (3) step();
    req_valid_in = 2'b00;
    reset_n_in   = 1'b1;

    // Fairness: both requesting, immediate done -> 0,1,0,1.
    for (int i = 0; i < 4; i++) run_job(2'b11, 1, 1'b0, 1'b1);

    // Single job, done on third WAIT cycle.
    run_job(2'b01, 3, 1'b0, 1'b0);
    // Timeout.
    run_job(2'b10, 0, 1'b0, 1'b0);
    // Stale done during START, done on the last WAIT cycle.
    run_job(2'b01, int'(TO), 1'b1, 1'b0);

    // Async reset in the middle of WAIT.
    step();
    req_valid_in = 2'b10;
    #1;
    check("pre_rst_ready", 32'(req_ready_out), 32'(pick(2'b10, last_w) + 1));
    step();
    req_valid_in = 2'b00;
    repeat (3) step();
    req_valid_in = 2'b11;
    reset_n_in   = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_block", 32'(rf_write_block_out), 32'd0);
    check("midrst_ready", 32'(req_ready_out), 32'd0);
    check("midrst_rsp", 32'(rsp_valid_out), 32'd0);
    step();
    req_valid_in = 2'b00;
    reset_n_in   = 1'b1;
    last_w = NREQ - 1;
    m_jobs = 0;
    m_tos  = 0;
    m_busy = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("post_rst_no_rsp", 32'(rsp_valid_out), 32'd0);
      check("post_rst_no_start", 32'(tc_start_out), 32'd0);
    end
    // Pointer is back at its reset value: requester 0 wins.
    run_job(2'b11, 2, 1'b0, 1'b0);

    // Randomized jobs with idle gaps.
    for (int j = 0; j < 24; j++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        check("gap_idle_ready", 32'(req_ready_out), 32'd0);
      end
      run_job(2'($urandom_range(1, 3)), int'($urandom_range(0, TO)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef TENSOR_SCHED_PERF_EN
    step();
    check("perf_jobs", 32'(perf_jobs_out), 32'(m_jobs));
    check("perf_timeouts", 32'(perf_timeouts_out), 32'(m_tos));
    check("perf_busy", perf_busy_cycles_out, 32'(m_busy));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
